// File: rtl/inc_dec_pulse_gen.sv
// Button front-end for the inc/dec counter: sync, debounce, edge detect and arbitration per channel.
// Optional auto-repeat while a button is held is built when AUTO_REPEAT_EN is defined.
module inc_dec_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_dn,
    output logic inc,
    output logic dec,
    output logic up_level,
    output logic dn_level
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PRESS  = 2'd1;
`ifdef AUTO_REPEAT_EN
    localparam logic [1:0] ST_DELAY  = 2'd2;
    localparam logic [1:0] ST_REPEAT = 2'd3;
`else
    localparam logic [1:0] ST_HELD   = 2'd2;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic [1:0] btn_w;
    logic [1:0] level_w;
    logic [1:0] pulse_w;

    assign btn_w = {btn_dn, btn_up};

    // Channel 0 is up/inc, channel 1 is down/dec.
    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic             sync1_q, sync2_q;
        logic             level_q, level_d;
        logic             pulse_q, pulse_d;
        logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
        logic [1:0]       st_q, st_d;
        logic             other_lvl;
`ifdef AUTO_REPEAT_EN
        logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

        assign other_lvl  = level_w[1-g];
        assign level_w[g] = level_q;
        assign pulse_w[g] = pulse_q;

        always_comb begin
            db_cnt_d = db_cnt_q;
            level_d  = level_q;
            if (sync2_q == level_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d  = sync2_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = sat_inc(db_cnt_q);
            end
        end

        // A pulse is only granted while the opposite level is low; this also drops simultaneous requests.
        always_comb begin
            st_d    = st_q;
            pulse_d = 1'b0;
`ifdef AUTO_REPEAT_EN
            rpt_cnt_d = rpt_cnt_q;
`endif
            case (st_q)
                ST_IDLE: begin
                    if (level_q) begin
                        st_d    = ST_PRESS;
                        pulse_d = ~other_lvl;
`ifdef AUTO_REPEAT_EN
                        rpt_cnt_d = CNT_W'(1);
`endif
                    end
                end
                ST_PRESS: begin
                    if (!level_q) begin
                        st_d = ST_IDLE;
                    end else begin
`ifdef AUTO_REPEAT_EN
                        st_d      = ST_DELAY;
                        rpt_cnt_d = sat_inc(rpt_cnt_q);
`else
                        st_d = ST_HELD;
`endif
                    end
                end
`ifdef AUTO_REPEAT_EN
                ST_DELAY, ST_REPEAT: begin
                    if (!level_q) begin
                        st_d = ST_IDLE;
                    end else if (!other_lvl) begin
                        if (rpt_cnt_q >= ((st_q == ST_DELAY) ? CNT_W'(REPEAT_DELAY)
                                                              : CNT_W'(REPEAT_RATE))) begin
                            st_d      = ST_REPEAT;
                            pulse_d   = 1'b1;
                            rpt_cnt_d = CNT_W'(1);
                        end else begin
                            rpt_cnt_d = sat_inc(rpt_cnt_q);
                        end
                    end
                end
`else
                ST_HELD: begin
                    if (!level_q) st_d = ST_IDLE;
                end
`endif
                default: st_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                level_q  <= 1'b0;
                db_cnt_q <= '0;
                st_q     <= ST_IDLE;
                pulse_q  <= 1'b0;
`ifdef AUTO_REPEAT_EN
                rpt_cnt_q <= '0;
`endif
            end else begin
                sync1_q  <= btn_w[g];
                sync2_q  <= sync1_q;
                level_q  <= level_d;
                db_cnt_q <= db_cnt_d;
                st_q     <= st_d;
                pulse_q  <= pulse_d;
`ifdef AUTO_REPEAT_EN
                rpt_cnt_q <= rpt_cnt_d;
`endif
            end
        end
    end

    assign inc      = pulse_w[0];
    assign dec      = pulse_w[1];
    assign up_level = level_w[0];
    assign dn_level = level_w[1];

endmodule

// File: tb/tb_inc_dec_pulse_gen.sv
// Directed bench for inc_dec_pulse_gen: per-cycle vector table plus hand sequences for
// bounce, reset-during-debounce and held-button behaviour (AUTO_REPEAT_EN aware).
module tb_inc_dec_pulse_gen;

    logic clk, rst, btn_up, btn_dn;
    logic inc, dec, up_level, dn_level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic up, dn;
        logic e_inc, e_dec, e_upl, e_dnl;
    } vec_t;

    vec_t tbl[$];

    inc_dec_pulse_gen #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (16),
        .REPEAT_RATE    (4),
        .CNT_W          (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_up  (btn_up),
        .btn_dn  (btn_dn),
        .inc     (inc),
        .dec     (dec),
        .up_level(up_level),
        .dn_level(dn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input logic up, input logic dn, input logic ei,
                                input logic ed, input logic eu, input logic en);
        vec_t v;
        v.up = up; v.dn = dn; v.e_inc = ei; v.e_dec = ed; v.e_upl = eu; v.e_dnl = en;
        tbl.push_back(v);
    endfunction

    // inc and dec must never be high together
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (inc && dec) begin
                errors++;
                $display("FAIL exclusive: inc=%b dec=%b expected not both 1", inc, dec);
            end
        end
    end

    initial begin
        int dec_cnt;
        int dec_row;
        logic exp_inc;

        rst = 1'b1; btn_up = 1'b0; btn_dn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_inc", inc, 1'b0);
        chk("rst_dec", dec, 1'b0);
        chk("rst_upl", up_level, 1'b0);
        chk("rst_dnl", dn_level, 1'b0);
        rst = 1'b0;

        // idle after reset
        for (int k = 1; k <= 50; k++) add(0, 0, 0, 0, 0, 0);
        // clean up press, held 10 cycles, then release
        for (int k = 1; k <= 10; k++) add(1, 0, k == 7, 0, k >= 6, 0);
        for (int k = 1; k <= 10; k++) add(0, 0, 0, 0, k < 6, 0);
        // both buttons rise together, then release
        for (int k = 1; k <= 10; k++) add(1, 1, 0, 0, k >= 6, k >= 6);
        for (int k = 1; k <= 10; k++) add(0, 0, 0, 0, k < 6, k < 6);

        for (int i = 0; i < tbl.size(); i++) begin
            btn_up = tbl[i].up;
            btn_dn = tbl[i].dn;
            @(negedge clk);
            chk($sformatf("tbl%0d_inc", i), inc, tbl[i].e_inc);
            chk($sformatf("tbl%0d_dec", i), dec, tbl[i].e_dec);
            chk($sformatf("tbl%0d_upl", i), up_level, tbl[i].e_upl);
            chk($sformatf("tbl%0d_dnl", i), dn_level, tbl[i].e_dnl);
        end

        // bouncing down button: 2-cycle runs for 20 cycles, then held from row 21
        dec_cnt = 0;
        dec_row = 0;
        for (int r = 1; r <= 50; r++) begin
            btn_dn = (r <= 20) ? (((r - 1) / 2) % 2 == 0) : 1'b1;
            @(negedge clk);
            if (dec) begin
                dec_cnt++;
                dec_row = r;
            end
            chk($sformatf("bounce%0d_inc", r), inc, 1'b0);
        end
        chk_int("bounce_dec_count", dec_cnt, 1);
        chk_int("bounce_dec_row", dec_row, 27);
        btn_dn = 1'b0;
        repeat (12) @(negedge clk);
        chk("bounce_rel_dnl", dn_level, 1'b0);

        // reset two cycles into the debounce of btn_up
        btn_up = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_db_inc", inc, 1'b0);
        chk("mid_db_upl", up_level, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_inc", inc, 1'b0);
        chk("mid_rst_upl", up_level, 1'b0);
        rst = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_inc", r), inc, r == 7);
            chk($sformatf("post_rst%0d_upl", r), up_level, r >= 6);
        end
        btn_up = 1'b0;
        for (int r = 1; r <= 12; r++) begin
            @(negedge clk);
            chk($sformatf("post_rst_rel%0d_inc", r), inc, 1'b0);
        end

        // long hold: first pulse at row 7, repeats every 4 from row 23 when enabled
        for (int r = 1; r <= 60; r++) begin
            btn_up = (r <= 43);
            @(negedge clk);
`ifdef AUTO_REPEAT_EN
            exp_inc = (r == 7) || (r >= 23 && r <= 47 && ((r - 23) % 4 == 0));
`else
            exp_inc = (r == 7);
`endif
            chk($sformatf("hold%0d_inc", r), inc, exp_inc);
            chk($sformatf("hold%0d_upl", r), up_level, r >= 6 && r <= 48);
            chk($sformatf("hold%0d_dec", r), dec, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
